// File: rtl/regfile_bank_clr_if.sv
// Request/response bundle for regfile_bank_clr: write, dual read and bulk-clear.
interface regfile_bank_clr_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  en;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [ADDR_WIDTH-1:0] rd_addr2;
    logic [DATA_WIDTH-1:0] rd_data1;
    logic [DATA_WIDTH-1:0] rd_data2;
    logic                  rd_valid;
    logic                  clr_req;
    logic                  busy;

    modport master (
        output en, wr, wr_addr, wr_data, wr_be, rd, rd_addr1, rd_addr2, clr_req,
        input  rd_data1, rd_data2, rd_valid, busy
    );

    modport slave (
        input  en, wr, wr_addr, wr_data, wr_be, rd, rd_addr1, rd_addr2, clr_req,
        output rd_data1, rd_data2, rd_valid, busy
    );
endinterface

// File: rtl/regfile_bank_clr.sv
// Byte-enabled register file with two registered read ports, optional
// write-to-read forwarding, optional hard-wired zero entry and a bulk clear
// sequencer that zeroes one entry per enabled cycle.
module regfile_bank_clr #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter bit          ZERO_REG   = 1'b0,
    parameter bit          BYPASS     = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_bank_clr_if.slave   bus
);
    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_we;
    logic                  busy_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_next1, rd_next2;
    logic [DATA_WIDTH-1:0] rd_data1_q, rd_data2_q;
    logic                  rd_valid_q;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(BE_WIDTH); b++) begin
            if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    // Accepted user traffic: only in IDLE with the global enable high.
    assign wr_acc = bus.en && (state_q == ST_IDLE) && bus.wr &&
                    !(ZERO_REG && (bus.wr_addr == '0));
    assign rd_acc = bus.en && (state_q == ST_IDLE) && bus.rd;

    // State, clear counter and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_CLEAR);
        end
    end

    // Next-state logic: clear sequencer walks every entry once, pausing on en=0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        if (bus.en) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
                    end
                end
                ST_CLEAR: begin
                    clr_we = 1'b1;
                    if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Storage array: clear writes take priority (user writes are blocked in CLEAR anyway).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem[bus.wr_addr] <= merge_bytes(mem[bus.wr_addr], bus.wr_data, bus.wr_be);
        end
    end

    // Read-port values including optional same-cycle forwarding and zero entry.
    always_comb begin
        rd_next1 = mem[bus.rd_addr1];
        rd_next2 = mem[bus.rd_addr2];
        if (BYPASS && wr_acc && (bus.rd_addr1 == bus.wr_addr))
            rd_next1 = merge_bytes(mem[bus.rd_addr1], bus.wr_data, bus.wr_be);
        if (BYPASS && wr_acc && (bus.rd_addr2 == bus.wr_addr))
            rd_next2 = merge_bytes(mem[bus.rd_addr2], bus.wr_data, bus.wr_be);
        if (ZERO_REG && (bus.rd_addr1 == '0)) rd_next1 = '0;
        if (ZERO_REG && (bus.rd_addr2 == '0)) rd_next2 = '0;
    end

    // Registered read outputs; data holds whenever no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data1_q <= rd_next1;
                rd_data2_q <= rd_next2;
            end
        end
    end

    assign bus.rd_data1 = rd_data1_q;
    assign bus.rd_data2 = rd_data2_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_regfile_bank_clr.sv
// Directed bench: dut0 uses defaults (BYPASS=1, ZERO_REG=0), dut1 uses
// ZERO_REG=1, BYPASS=0; both see identical stimulus.
module tb_regfile_bank_clr;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_bank_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();
    regfile_bank_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();

    assign bus1.en       = bus0.en;
    assign bus1.wr       = bus0.wr;
    assign bus1.wr_addr  = bus0.wr_addr;
    assign bus1.wr_data  = bus0.wr_data;
    assign bus1.wr_be    = bus0.wr_be;
    assign bus1.rd       = bus0.rd;
    assign bus1.rd_addr1 = bus0.rd_addr1;
    assign bus1.rd_addr2 = bus0.rd_addr2;
    assign bus1.clr_req  = bus0.clr_req;

    regfile_bank_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1'b0), .BYPASS(1'b1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    regfile_bank_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1'b1), .BYPASS(1'b0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.en = 1'b1; bus0.wr = 1'b0; bus0.rd = 1'b0; bus0.clr_req = 1'b0;
        bus0.wr_addr = '0; bus0.wr_data = '0; bus0.wr_be = '0;
        bus0.rd_addr1 = '0; bus0.rd_addr2 = '0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        bus0.wr = 1'b1; bus0.wr_addr = a; bus0.wr_data = d; bus0.wr_be = be;
        tick();
        bus0.wr = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a1, input logic [3:0] a2);
        bus0.rd = 1'b1; bus0.rd_addr1 = a1; bus0.rd_addr2 = a2;
        tick();
        bus0.rd = 1'b0;
    endtask

    task automatic wait_clear_done(input string name);
        int guard = 0;
        while ((bus0.busy || bus1.busy) && guard < 100) begin
            tick();
            guard++;
        end
        n_tests++;
        if (bus0.busy || bus1.busy) begin
            n_fail++;
            $display("FAIL %s_timeout: busy0=%0b busy1=%0b still set, required 0", name, bus0.busy, bus1.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        n_tests++;
        if (bus0.busy !== 1'b0 || bus0.rd_valid !== 1'b0 || bus0.rd_data1 !== 32'h0 ||
            bus0.rd_data2 !== 32'h0 || bus1.busy !== 1'b0 || bus1.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%0b valid=%0b d1=%h d2=%h busy1=%0b valid1=%0b, required all 0",
                     bus0.busy, bus0.rd_valid, bus0.rd_data1, bus0.rd_data2, bus1.busy, bus1.rd_valid);
        end
        #20;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        do_write(4'd5, 32'hDEADBEEF, 4'hF);
        do_read(4'd5, 4'd0);
        n_tests++;
        if (bus0.rd_data1 !== 32'hDEADBEEF || bus0.rd_data2 !== 32'h0 || bus0.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_dut0: d1=%h d2=%h v=%0b, required deadbeef 00000000 1",
                     bus0.rd_data1, bus0.rd_data2, bus0.rd_valid);
        end
        n_tests++;
        if (bus1.rd_data1 !== 32'hDEADBEEF || bus1.rd_data2 !== 32'h0 || bus1.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_dut1: d1=%h d2=%h v=%0b, required deadbeef 00000000 1",
                     bus1.rd_data1, bus1.rd_data2, bus1.rd_valid);
        end
        tick();
        n_tests++;
        if (bus0.rd_valid !== 1'b0 || bus0.rd_data1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_rd_pulse: v=%0b d1=%h, required 0 deadbeef (held)", bus0.rd_valid, bus0.rd_data1);
        end
    endtask

    task automatic test_byte_enable();
        do_write(4'd3, 32'h11223344, 4'hF);
        do_write(4'd3, 32'hAABBCCDD, 4'b0101);
        tick();
        do_read(4'd3, 4'd3);
        n_tests++;
        if (bus0.rd_data1 !== 32'h11BB33DD || bus1.rd_data2 !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL byte_enable: d1=%h d2_dut1=%h, required 11bb33dd", bus0.rd_data1, bus1.rd_data2);
        end
    endtask

    task automatic test_bypass();
        bus0.wr = 1'b1; bus0.wr_addr = 4'd7; bus0.wr_data = 32'h12345678; bus0.wr_be = 4'hF;
        bus0.rd = 1'b1; bus0.rd_addr1 = 4'd7; bus0.rd_addr2 = 4'd7;
        tick();
        bus0.wr = 1'b0; bus0.rd = 1'b0;
        n_tests++;
        if (bus0.rd_data1 !== 32'h12345678 || bus0.rd_data2 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_on: d1=%h d2=%h, required 12345678 12345678", bus0.rd_data1, bus0.rd_data2);
        end
        n_tests++;
        if (bus1.rd_data1 !== 32'h0 || bus1.rd_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_off: d1=%h d2=%h, required 00000000 00000000", bus1.rd_data1, bus1.rd_data2);
        end
        // Partial byte-enable forwarding on one port only.
        bus0.wr = 1'b1; bus0.wr_addr = 4'd7; bus0.wr_data = 32'hFFFF0000; bus0.wr_be = 4'b1000;
        bus0.rd = 1'b1; bus0.rd_addr1 = 4'd5; bus0.rd_addr2 = 4'd7;
        tick();
        bus0.wr = 1'b0; bus0.rd = 1'b0;
        n_tests++;
        if (bus0.rd_data1 !== 32'hDEADBEEF || bus0.rd_data2 !== 32'hFF345678 || bus1.rd_data2 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_partial: d1=%h d2=%h d2_dut1=%h, required deadbeef ff345678 12345678",
                     bus0.rd_data1, bus0.rd_data2, bus1.rd_data2);
        end
    endtask

    task automatic test_zero_reg();
        do_write(4'd0, 32'hFFFFFFFF, 4'hF);
        do_read(4'd0, 4'd0);
        n_tests++;
        if (bus0.rd_data1 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL zero_reg_off: d1=%h, required ffffffff", bus0.rd_data1);
        end
        n_tests++;
        if (bus1.rd_data1 !== 32'h0 || bus1.rd_data2 !== 32'h0 || bus1.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_reg_on: d1=%h d2=%h v=%0b, required 00000000 00000000 1",
                     bus1.rd_data1, bus1.rd_data2, bus1.rd_valid);
        end
    endtask

    task automatic test_enable_idle();
        bus0.en = 1'b0;
        do_write(4'd5, 32'h0BADF00D, 4'hF);
        do_read(4'd5, 4'd5);
        n_tests++;
        if (bus0.rd_valid !== 1'b0 || bus0.rd_data1 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL en_low_idle: v=%0b d1=%h, required 0 ffffffff (held)", bus0.rd_valid, bus0.rd_data1);
        end
        bus0.en = 1'b1;
        do_read(4'd5, 4'd5);
        n_tests++;
        if (bus0.rd_data1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL en_low_write: d1=%h, required deadbeef", bus0.rd_data1);
        end
    endtask

    task automatic test_clear();
        int cnt0 = 0;
        int cnt1 = 0;
        int bad_valid = 0;
        int guard = 0;
        int bad_entries = 0;
        for (int i = 0; i < 16; i++) do_write(4'(i), 32'h01010101 * (i + 1), 4'hF);
        do_read(4'd2, 4'd9);
        bus0.clr_req = 1'b1;
        tick();
        bus0.clr_req = 1'b0;
        bus0.rd = 1'b1; bus0.rd_addr1 = 4'd4; bus0.rd_addr2 = 4'd11;
        while ((bus0.busy || bus1.busy) && guard < 40) begin
            if (bus0.busy) cnt0++;
            if (bus1.busy) cnt1++;
            if (bus0.rd_valid || bus1.rd_valid) bad_valid++;
            bus0.clr_req = (guard == 5);
            tick();
            guard++;
        end
        if (bus0.rd_valid || bus1.rd_valid) bad_valid++;
        bus0.rd = 1'b0; bus0.clr_req = 1'b0;
        n_tests++;
        if (cnt0 != 16 || cnt1 != 16) begin
            n_fail++;
            $display("FAIL clear_busy_len: cycles0=%0d cycles1=%0d, required 16", cnt0, cnt1);
        end
        n_tests++;
        if (bad_valid != 0) begin
            n_fail++;
            $display("FAIL clear_rd_valid: %0d cycles with rd_valid=1, required 0", bad_valid);
        end
        n_tests++;
        if (bus0.rd_data1 !== 32'h03030303 || bus0.rd_data2 !== 32'h0A0A0A0A) begin
            n_fail++;
            $display("FAIL clear_hold: d1=%h d2=%h, required 03030303 0a0a0a0a", bus0.rd_data1, bus0.rd_data2);
        end
        for (int i = 0; i < 8; i++) begin
            do_read(4'(i), 4'(i + 8));
            if (bus0.rd_data1 !== 32'h0 || bus0.rd_data2 !== 32'h0 ||
                bus1.rd_data1 !== 32'h0 || bus1.rd_data2 !== 32'h0) bad_entries++;
        end
        n_tests++;
        if (bad_entries != 0) begin
            n_fail++;
            $display("FAIL clear_entries: %0d read pairs nonzero, required 0", bad_entries);
        end
    endtask

    task automatic test_clr_with_wr();
        bus0.wr = 1'b1; bus0.wr_addr = 4'd4; bus0.wr_data = 32'h44440000; bus0.wr_be = 4'hF;
        bus0.rd = 1'b1; bus0.rd_addr1 = 4'd4; bus0.rd_addr2 = 4'd5;
        bus0.clr_req = 1'b1;
        tick();
        idle_inputs();
        n_tests++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_data1 !== 32'h44440000 || bus1.rd_data1 !== 32'h0 ||
            bus0.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_with_wr: v=%0b d1=%h d1_dut1=%h busy=%0b, required 1 44440000 00000000 1",
                     bus0.rd_valid, bus0.rd_data1, bus1.rd_data1, bus0.busy);
        end
        wait_clear_done("clr_with_wr");
    endtask

    task automatic test_enable_pause();
        int en_cycles = 0;
        int iter = 0;
        int bad_busy = 0;
        do_write(4'd14, 32'h55555555, 4'hF);
        do_write(4'd15, 32'h66666666, 4'hF);
        bus0.clr_req = 1'b1;
        tick();
        bus0.clr_req = 1'b0;
        while (bus0.busy && iter < 60) begin
            bus0.en = !(iter >= 4 && iter <= 6);
            tick();
            if (bus0.en) en_cycles++;
            else if (!bus0.busy || !bus1.busy) bad_busy++;
            iter++;
        end
        bus0.en = 1'b1;
        n_tests++;
        if (en_cycles != 16) begin
            n_fail++;
            $display("FAIL pause_count: enabled clear cycles=%0d, required 16", en_cycles);
        end
        n_tests++;
        if (bad_busy != 0) begin
            n_fail++;
            $display("FAIL pause_busy: busy dropped in %0d paused cycles, required 0", bad_busy);
        end
        wait_clear_done("pause");
        do_read(4'd15, 4'd14);
        n_tests++;
        if (bus0.rd_data1 !== 32'h0 || bus0.rd_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL pause_entries: d1=%h d2=%h, required 00000000 00000000", bus0.rd_data1, bus0.rd_data2);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_write(4'd12, 32'hCAFE1234, 4'hF);
        do_read(4'd12, 4'd12);
        bus0.clr_req = 1'b1;
        tick();
        bus0.clr_req = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus0.busy !== 1'b0 || bus0.rd_data1 !== 32'h0 || bus0.rd_data2 !== 32'h0 ||
            bus0.rd_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.rd_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: busy=%0b d1=%h d2=%h v=%0b busy1=%0b d1_dut1=%h, required all 0",
                     bus0.busy, bus0.rd_data1, bus0.rd_data2, bus0.rd_valid, bus1.busy, bus1.rd_data1);
        end
        #10;
        rst_n = 1'b1;
        do_write(4'd13, 32'h13131313, 4'hF);
        n_tests++;
        if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy0=%0b busy1=%0b, required 0", bus0.busy, bus1.busy);
        end
        do_read(4'd13, 4'd12);
        n_tests++;
        if (bus0.rd_data1 !== 32'h13131313 || bus0.rd_data2 !== 32'h0 || bus0.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_array: d1=%h d2=%h v=%0b, required 13131313 00000000 1",
                     bus0.rd_data1, bus0.rd_data2, bus0.rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_bypass();
        test_zero_reg();
        test_enable_idle();
        test_clear();
        test_clr_with_wr();
        test_enable_pause();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_bank_clr.md
REGFILE_BANK_CLR -- requirements
Module: regfile_bank_clr

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning entry width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 0, meaning entry 0 always reads as zero and ignores writes when set to 1.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning a same-cycle write is forwarded to a matching read when set to 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: global enable; when 0 all state holds.
REQ-008 The block SHALL have ports wr (input, 1), wr_addr (input, ADDR_WIDTH), wr_data (input, DATA_WIDTH) and wr_be (input, DATA_WIDTH/8): write request, address, data and per-byte enable.
REQ-009 The block SHALL have ports rd (input, 1), rd_addr1 (input, ADDR_WIDTH) and rd_addr2 (input, ADDR_WIDTH): read request and the two read addresses.
REQ-010 The block SHALL have ports rd_data1 and rd_data2 (output, DATA_WIDTH each) and rd_valid (output, 1): registered read data and a one-cycle valid pulse.
REQ-011 The block SHALL have ports clr_req (input, 1) and busy (output, 1): bulk-clear request, and high while a clear is in progress.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and CLEAR.
REQ-013 In IDLE with en=1, clr_req=1 SHALL move the FSM to CLEAR and load the clear counter with 0.
REQ-014 In CLEAR with en=1, each cycle SHALL write zero to entry[counter] and increment the counter.
- On the cycle counter = DEPTH-1, the FSM SHALL return to IDLE.
- A clear therefore takes exactly DEPTH cycles.
REQ-015 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-016 clr_req asserted while in CLEAR SHALL be ignored; it neither restarts nor extends the clear.
REQ-017 In CLEAR, wr and rd SHALL be ignored: no array update, rd_valid=0, and rd_data1/rd_data2 hold.
REQ-018 In IDLE with en=1 and wr=1, each byte b of entry[wr_addr] with wr_be[b]=1 SHALL be updated at the clock edge; bytes with wr_be[b]=0 keep their value.
REQ-019 With ZERO_REG=1, a write to address 0 SHALL have no effect, and any read of address 0 SHALL return 0.
REQ-020 In IDLE with en=1 and rd=1, rd_data1 and rd_data2 SHALL present entry[rd_addr1] and entry[rd_addr2] one cycle later, with rd_valid=1 in that same cycle.
REQ-021 When rd=0, en=0 or the FSM is in CLEAR, rd_valid SHALL be 0 on the next cycle and rd_data1/rd_data2 SHALL hold their previous values.
REQ-022 If wr and rd are accepted in the same cycle and a read address equals wr_addr:
- With BYPASS=1, that read SHALL return the byte-merged new value (new bytes where wr_be=1, old bytes elsewhere).
- With BYPASS=0, that read SHALL return the pre-write value.
REQ-023 Bypass SHALL apply independently to each read port; both ports may hit the same address.
REQ-024 clr_req and wr/rd accepted in the same IDLE cycle: wr and rd SHALL complete normally in that cycle, and the clear SHALL start on the next cycle.
REQ-025 With en=0, the FSM, counter, array and outputs SHALL all hold; rd_valid SHALL go to 0; a clear in progress SHALL pause and then resume at the same counter value.

Reset
REQ-026 When rst_n=0, asynchronously and without a clock:
- all array entries SHALL be set to 0;
- rd_data1, rd_data2, rd_valid and busy SHALL be set to 0;
- the FSM SHALL be set to IDLE and the counter to 0.
REQ-027 Reset asserted during CLEAR SHALL abort the clear immediately; after reset release the block SHALL be in IDLE with busy=0.
REQ-028 The first clock edge after rst_n rises SHALL be treated as a normal IDLE cycle.

Verification
REQ-029 Write/read check: write 0xDEADBEEF to address 5 with wr_be=4'hF, then rd with rd_addr1=5 and rd_addr2=0 -> next cycle rd_data1=0xDEADBEEF, rd_data2=0, rd_valid=1 for exactly one cycle.
REQ-030 Byte-enable check: entry 3 holds 0x11223344; write 0xAABBCCDD with wr_be=4'b0101 -> a later read of address 3 returns 0x11BB33DD.
REQ-031 Bypass check: entry 7 holds 0x0; wr to address 7 with 0x12345678 and wr_be=4'hF, plus rd with rd_addr1=rd_addr2=7, in the same cycle -> both outputs return 0x12345678 (BYPASS=1), or both return 0x0 (BYPASS=0).
REQ-032 Clear check: fill all 16 entries with nonzero data, pulse clr_req -> busy is high for exactly 16 cycles, rd requests in that window give rd_valid=0, and afterwards every entry reads 0.
REQ-033 ZERO_REG check: with ZERO_REG=1, write 0xFFFFFFFF to address 0 -> a read of address 0 returns 0.
REQ-034 Enable and reset check: drop en for 3 cycles mid-clear -> busy stays high and the total count of en=1 clear cycles is still 16; assert rst_n=0 mid-clear -> busy=0 and all outputs 0 immediately, with no clock edge.
